// File: rtl/ram_line_bridge_pkg.sv
// Shared types and sizing for the line-to-byte RAM bridge.
package ram_bridge_pkg;

  localparam int ADDR_SIZE_DEF = 12;
  localparam int WORD_SIZE_DEF = 8;
  localparam int DATA_SIZE_DEF = 128;
  localparam int TIMEOUT_DEF   = 64;

  localparam int ITER_COUNT   = DATA_SIZE_DEF / WORD_SIZE_DEF;
  localparam int QUIET_CYCLES = ITER_COUNT + 2;
  localparam int BEAT_W       = $clog2(ITER_COUNT);

  typedef enum logic [2:0] {
    QUIET, IDLE, WR_SEND, WR_WAIT, RD_WAIT, RD_RECV, DONE
  } state_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter serves both the ack timeout and the post-reset drain window.
  localparam int TMO_W = $clog2(max_i(TIMEOUT_DEF, QUIET_CYCLES));

endpackage

// File: rtl/ram_line_bridge_if.sv
// Request/response line channel and byte-serial RAM bus.
interface line_req_if #(
  parameter int ADDR_SIZE = 12,
  parameter int DATA_SIZE = 128
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_err;
  logic [DATA_SIZE-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface ram_bus_if #(
  parameter int ADDR_SIZE = 12,
  parameter int WORD_SIZE = 8
);
  logic [ADDR_SIZE-1:0] ram_addr;
  logic                 ram_avalid;
  logic                 ram_rnw;
  logic [WORD_SIZE-1:0] ram_wdata;
  logic [WORD_SIZE-1:0] ram_rdata;
  logic                 ram_ack;

  modport master (
    output ram_addr, ram_avalid, ram_rnw, ram_wdata,
    input  ram_rdata, ram_ack
  );
  modport slave (
    input  ram_addr, ram_avalid, ram_rnw, ram_wdata,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/ram_line_bridge_line_serdes.sv
// Line register: whole-line load, byte-lane select for shift-out, byte-lane capture for reads.
module line_serdes #(
  parameter int WORD_SIZE = 8,
  parameter int ITER      = 16,
  parameter int BW        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [ITER*WORD_SIZE-1:0] load_line,
  input  logic                      lane_we,
  input  logic [BW-1:0]             lane_sel,
  input  logic [WORD_SIZE-1:0]      lane_din,
  output logic [ITER*WORD_SIZE-1:0] line,
  output logic [WORD_SIZE-1:0]      lane_out
);

  logic [ITER-1:0][WORD_SIZE-1:0] lanes;

  for (genvar i = 0; i < ITER; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst)
        lanes[i] <= '0;
      else if (load)
        lanes[i] <= load_line[i*WORD_SIZE +: WORD_SIZE];
      else if (lane_we && lane_sel == BW'(i))
        lanes[i] <= lane_din;
    end
  end

  assign line     = lanes;
  assign lane_out = lanes[lane_sel];

endmodule

// File: rtl/ram_line_bridge.sv
// Bridges 128-bit line requests onto the byte-serial RAM bus, one transaction in flight.
module ram_line_bridge
  import ram_bridge_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic      ram_clk,
  input  logic      ram_rst,
  line_req_if.slave req,
  ram_bus_if.master ram
);

  localparam int ITER = DATA_SIZE / WORD_SIZE;
  localparam int BW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int TW   = $clog2(max_i(TIMEOUT, ITER + 2));

  localparam logic [BW-1:0] LAST_BEAT  = BW'(ITER - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] QUIET_LAST = TW'(ITER + 1);

  state_e               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 avalid_q, avalid_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic                 rnw_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] rdata_q;

  logic                 accept, lane_we, rdata_load, stall;
  logic [DATA_SIZE-1:0] line;
  logic [WORD_SIZE-1:0] lane_out;

  line_serdes #(
    .WORD_SIZE (WORD_SIZE),
    .ITER      (ITER),
    .BW        (BW)
  ) u_serdes (
    .clk       (ram_clk),
    .rst       (ram_rst),
    .load      (accept & req.req_we),
    .load_line (req.req_wdata),
    .lane_we   (lane_we),
    .lane_sel  (beat_q),
    .lane_din  (ram.ram_rdata),
    .line      (line),
    .lane_out  (lane_out)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    tmo_d        = tmo_q;
    avalid_d     = avalid_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    accept       = 1'b0;
    lane_we      = 1'b0;
    rdata_load   = 1'b0;
    stall        = 1'b0;

    case (state_q)
      QUIET: begin
        // Let any RAM burst cut short by reset/abort run out before taking work.
        avalid_d = 1'b0;
        if (tmo_q == QUIET_LAST) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      IDLE: begin
        if (req.req_valid) begin
          accept   = 1'b1;
          avalid_d = 1'b1;
          beat_d   = '0;
          tmo_d    = '0;
          state_d  = req.req_we ? WR_SEND : RD_WAIT;
        end
      end
      WR_SEND: begin
        tmo_d = '0;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = WR_WAIT;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WR_WAIT: begin
        if (ram.ram_ack) begin
          tmo_d   = '0;
          state_d = DONE;
        end else begin
          stall = 1'b1;
        end
      end
      RD_WAIT, RD_RECV: begin
        if (ram.ram_ack) begin
          lane_we = 1'b1;
          tmo_d   = '0;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = RD_RECV;
          end
        end else begin
          stall = 1'b1;
        end
      end
      DONE: begin
        // avalid drops here; IDLE then gives the single low cycle before the next accept.
        avalid_d     = 1'b0;
        resp_valid_d = 1'b1;
        rdata_load   = rnw_q;
        state_d      = IDLE;
      end
      default: state_d = QUIET;
    endcase

    if (stall) begin
      if (tmo_q == TMO_LAST) begin
        state_d      = QUIET;
        tmo_d        = '0;
        beat_d       = '0;
        avalid_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      state_q      <= QUIET;
      beat_q       <= '0;
      tmo_q        <= '0;
      avalid_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rnw_q        <= 1'b0;
      addr_q       <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      tmo_q        <= tmo_d;
      avalid_q     <= avalid_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      if (accept) begin
        rnw_q  <= ~req.req_we;
        addr_q <= req.req_addr;
      end
      if (rdata_load)
        rdata_q <= line;
    end
  end

  assign req.req_ready  = (state_q == IDLE);
  assign req.resp_valid = resp_valid_q;
  assign req.resp_err   = resp_err_q;
  assign req.resp_rdata = rdata_q;

  assign ram.ram_addr   = addr_q;
  assign ram.ram_avalid = avalid_q;
  assign ram.ram_rnw    = rnw_q;
  assign ram.ram_wdata  = (state_q == WR_SEND) ? lane_out : '0;

endmodule

// File: tb/tb_ram_line_bridge.sv
// Directed bench for ram_line_bridge: writes, reads, ack stalls, back-to-back, timeout, reset abort.
module tb_ram_line_bridge;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic bad;

  always #5 clk = ~clk;

  line_req_if #(.ADDR_SIZE(12), .DATA_SIZE(128)) req_if ();
  ram_bus_if  #(.ADDR_SIZE(12), .WORD_SIZE(8))   ram_if ();

  ram_line_bridge dut (
    .ram_clk (clk),
    .ram_rst (rst),
    .req     (req_if),
    .ram     (ram_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_we    = 1'b0;
    req_if.req_addr  = '0;
    req_if.req_wdata = '0;
    ram_if.ram_ack   = 1'b0;
    ram_if.ram_rdata = '0;
    tick(); tick();

    // reset state
    chk("rst_ready",      req_if.req_ready,  0);
    chk("rst_avalid",     ram_if.ram_avalid, 0);
    chk("rst_resp_valid", req_if.resp_valid, 0);
    chk("rst_rdata",      req_if.resp_rdata, 0);
    chk("rst_wdata",      ram_if.ram_wdata,  0);
    rst = 1'b0;
    repeat (17) tick();
    chk("quiet_hold_ready", req_if.req_ready, 0);
    tick();
    chk("quiet_exit_ready", req_if.req_ready, 1);

    // write line 0x123
    req_if.req_valid = 1'b1;
    req_if.req_we    = 1'b1;
    req_if.req_addr  = 12'h123;
    req_if.req_wdata = 128'h0F0E0D0C0B0A09080706050403020100;
    tick();
    req_if.req_valid = 1'b0;
    chk("wr_ready_busy", req_if.req_ready, 0);
    chk("wr_avalid",     ram_if.ram_avalid, 1);
    chk("wr_rnw",        ram_if.ram_rnw,    0);
    for (int k = 0; k < 16; k++) begin
      chk("wr_beat", ram_if.ram_wdata, k);
      chk("wr_addr", ram_if.ram_addr,  12'h123);
      tick();
    end
    chk("wr_wait_wdata", ram_if.ram_wdata, 0);
    tick(); tick();
    chk("wr_wait_avalid", ram_if.ram_avalid, 1);
    chk("wr_wait_noresp", req_if.resp_valid, 0);
    ram_if.ram_ack = 1'b1;
    tick();
    ram_if.ram_ack = 1'b0;
    chk("wr_done_noresp", req_if.resp_valid, 0);
    tick();
    chk("wr_resp_valid",  req_if.resp_valid, 1);
    chk("wr_resp_err",    req_if.resp_err,   0);
    chk("wr_resp_avalid", ram_if.ram_avalid, 0);
    chk("wr_resp_ready",  req_if.req_ready,  1);

    // read line 0x3FF, RAM returns A0..AF after two idle cycles
    req_if.req_valid = 1'b1;
    req_if.req_we    = 1'b0;
    req_if.req_addr  = 12'h3FF;
    tick();
    req_if.req_valid = 1'b0;
    chk("wr_resp_pulse_end", req_if.resp_valid, 0);
    chk("rd_avalid", ram_if.ram_avalid, 1);
    chk("rd_rnw",    ram_if.ram_rnw,    1);
    chk("rd_addr",   ram_if.ram_addr,   12'h3FF);
    tick(); tick();
    for (int k = 0; k < 16; k++) begin
      ram_if.ram_ack   = 1'b1;
      ram_if.ram_rdata = 8'(8'hA0 + k);
      tick();
    end
    ram_if.ram_ack   = 1'b0;
    ram_if.ram_rdata = '0;
    chk("rd_done_noresp", req_if.resp_valid, 0);
    tick();
    chk("rd_resp_valid", req_if.resp_valid, 1);
    chk("rd_resp_err",   req_if.resp_err,   0);
    chk("rd_rdata",      req_if.resp_rdata, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    chk("rd_avalid_low", ram_if.ram_avalid, 0);
    tick();
    chk("rd_resp_pulse_end", req_if.resp_valid, 0);
    chk("rd_rdata_stable",   req_if.resp_rdata, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);

    // read with ack dropped for 3 cycles after beat 5
    req_if.req_valid = 1'b1;
    req_if.req_we    = 1'b0;
    req_if.req_addr  = 12'h055;
    tick();
    req_if.req_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin
        ram_if.ram_ack   = 1'b0;
        ram_if.ram_rdata = 8'hEE;
        repeat (3) tick();
        chk("stall_noresp", req_if.resp_valid, 0);
        chk("stall_avalid", ram_if.ram_avalid, 1);
      end
      ram_if.ram_ack   = 1'b1;
      ram_if.ram_rdata = 8'(k * 17);
      tick();
    end
    ram_if.ram_ack = 1'b0;
    tick();
    chk("stall_resp_valid", req_if.resp_valid, 1);
    chk("stall_rdata", req_if.resp_rdata, 128'hFFEEDDCCBBAA99887766554433221100);

    // write then read with req_valid held high
    req_if.req_valid = 1'b1;
    req_if.req_we    = 1'b1;
    req_if.req_addr  = 12'h200;
    req_if.req_wdata = 128'h11111111222222223333333344444444;
    tick();
    req_if.req_we   = 1'b0;
    req_if.req_addr = 12'h201;
    repeat (16) tick();
    ram_if.ram_ack = 1'b1;
    tick();
    ram_if.ram_ack = 1'b0;
    chk("b2b_done_avalid", ram_if.ram_avalid, 1);
    chk("b2b_pending",     req_if.req_ready,  0);
    tick();
    chk("b2b_gap_avalid", ram_if.ram_avalid, 0);
    chk("b2b_gap_resp",   req_if.resp_valid, 1);
    chk("b2b_gap_ready",  req_if.req_ready,  1);
    tick();
    req_if.req_valid = 1'b0;
    chk("b2b_rise2_avalid", ram_if.ram_avalid, 1);
    chk("b2b_rise2_rnw",    ram_if.ram_rnw,    1);
    chk("b2b_rise2_addr",   ram_if.ram_addr,   12'h201);
    for (int k = 0; k < 16; k++) begin
      ram_if.ram_ack   = 1'b1;
      ram_if.ram_rdata = 8'(8'h50 + k);
      tick();
    end
    ram_if.ram_ack = 1'b0;
    tick();
    chk("b2b_rd_resp",  req_if.resp_valid, 1);
    chk("b2b_rd_rdata", req_if.resp_rdata, 128'h5F5E5D5C5B5A59585756555453525150);

    // RAM never acks a read
    req_if.req_valid = 1'b1;
    req_if.req_we    = 1'b0;
    req_if.req_addr  = 12'h0AA;
    tick();
    req_if.req_valid = 1'b0;
    repeat (63) tick();
    chk("tmo_early_resp",   req_if.resp_valid, 0);
    chk("tmo_early_avalid", ram_if.ram_avalid, 1);
    tick();
    chk("tmo_resp_valid", req_if.resp_valid, 1);
    chk("tmo_resp_err",   req_if.resp_err,   1);
    chk("tmo_avalid",     ram_if.ram_avalid, 0);
    chk("tmo_ready",      req_if.req_ready,  0);
    chk("tmo_rdata_kept", req_if.resp_rdata, 128'h5F5E5D5C5B5A59585756555453525150);
    ram_if.ram_ack = 1'b1;
    bad = 1'b0;
    repeat (17) begin
      tick();
      if (req_if.req_ready || req_if.resp_valid || ram_if.ram_avalid) bad = 1'b1;
    end
    ram_if.ram_ack = 1'b0;
    chk("tmo_quiet", bad, 0);
    tick();
    chk("tmo_quiet_exit", req_if.req_ready, 1);

    // reset during write beat 7
    req_if.req_valid = 1'b1;
    req_if.req_we    = 1'b1;
    req_if.req_addr  = 12'h321;
    req_if.req_wdata = 128'h00112233445566778899AABBCCDDEEFF;
    tick();
    req_if.req_valid = 1'b0;
    repeat (7) tick();
    chk("rst_mid_beat7", ram_if.ram_wdata, 8'h88);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_avalid", ram_if.ram_avalid, 0);
    chk("rst_mid_resp",   req_if.resp_valid, 0);
    chk("rst_mid_ready",  req_if.req_ready,  0);
    chk("rst_mid_wdata",  ram_if.ram_wdata,  0);
    chk("rst_mid_rdata",  req_if.resp_rdata, 0);
    ram_if.ram_ack = 1'b1;
    bad = 1'b0;
    repeat (17) begin
      tick();
      if (req_if.req_ready || req_if.resp_valid || ram_if.ram_avalid) bad = 1'b1;
    end
    ram_if.ram_ack = 1'b0;
    chk("rst_mid_stray_ack", bad, 0);
    tick();
    chk("rst_mid_recover", req_if.req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
